// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
//   CPU control/status register block on the SPI bus side of the PET clone.
//   Holds three readable registers (CTRL, STEP, STATUS) at BASE_ADDR..+2 and
//   drives the 6502 RES and RDY lines. It provides a timed self-clearing reset
//   pulse, a counted single-step mode that parks the CPU in RDY between steps,
//   and a sticky STEP_DONE status flag.
//
// Ports:
//   clk_bus_i     in   bus clock, all logic on its rising edge
//   reset_i       in   synchronous active-high reset
//   spi_addr_i    in   SPI address (ADDR_WIDTH bits, full-width decode)
//   spi_data_i    in   SPI write data
//   spi_wr_en_i   in   one-cycle write strobe
//   spi_rd_en_i   in   one-cycle read strobe
//   spi_data_o    out  registered read data (holds when not hit)
//   spi_rd_hit_o  out  spi_data_o belongs to this block (same cycle as data)
//   cpu_done_i    in   one pulse per completed CPU bus cycle
//   cpu_res_o     out  CPU reset, active-high, registered
//   cpu_ready_o   out  CPU RDY, registered
// -----------------------------------------------------------------------------
module cpu_control #(
  parameter int                    ADDR_WIDTH       = 17,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 17'h0E80C,
  parameter int                    RES_PULSE_CYCLES = 16,
  parameter int                    STEP_WIDTH       = 8
) (
  input  logic                  clk_bus_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [7:0]            spi_data_i,
  input  logic                  spi_wr_en_i,
  input  logic                  spi_rd_en_i,
  output logic [7:0]            spi_data_o,
  output logic                  spi_rd_hit_o,
  input  logic                  cpu_done_i,
  output logic                  cpu_res_o,
  output logic                  cpu_ready_o
);

  localparam int PW = $clog2(RES_PULSE_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] LP_CTRL_ADDR   = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] LP_STEP_ADDR   = BASE_ADDR + ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(2);
  localparam logic [PW-1:0]         LP_PULSE_LOAD  = PW'(RES_PULSE_CYCLES);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_STEP  = 2'd3;

  logic                  r_res_n;
  logic                  r_run;
  logic [PW-1:0]         r_pulse_cnt;
  logic [STEP_WIDTH-1:0] r_step_cnt;
  logic                  r_step_done;
  logic [1:0]            r_state;
  logic                  r_cpu_res;
  logic                  r_cpu_ready;
  logic [7:0]            r_rd_data;
  logic                  r_rd_hit;

  logic                  w_hit_ctrl;
  logic                  w_hit_step;
  logic                  w_hit_status;
  logic                  w_wr_ctrl;
  logic                  w_wr_step;
  logic                  w_wr_status;
  logic                  w_res_n_nxt;
  logic                  w_run_nxt;
  logic [PW-1:0]         w_pulse_nxt;
  logic                  w_in_reset_nxt;
  logic [STEP_WIDTH-1:0] w_step_nxt;
  logic                  w_done_set;
  logic                  w_step_done_nxt;
  logic [1:0]            w_state_nxt;
  logic                  w_rd_hit;
  logic [7:0]            w_rd_data;

  assign w_hit_ctrl   = (spi_addr_i == LP_CTRL_ADDR);
  assign w_hit_step   = (spi_addr_i == LP_STEP_ADDR);
  assign w_hit_status = (spi_addr_i == LP_STATUS_ADDR);
  assign w_wr_ctrl    = spi_wr_en_i && w_hit_ctrl;
  assign w_wr_step    = spi_wr_en_i && w_hit_step;
  assign w_wr_status  = spi_wr_en_i && w_hit_status;

  // Next values of CTRL bits and the reset pulse counter.
  always_comb begin
    w_res_n_nxt = r_res_n;
    w_run_nxt   = r_run;
    w_pulse_nxt = r_pulse_cnt;
    if (w_wr_ctrl) begin
      w_res_n_nxt = spi_data_i[0];
      w_run_nxt   = spi_data_i[1];
    end else begin
      w_res_n_nxt = r_res_n;
      w_run_nxt   = r_run;
    end
    // A PULSE write always reloads the full length, even mid-pulse.
    if (w_wr_ctrl && spi_data_i[2]) begin
      w_pulse_nxt = LP_PULSE_LOAD;
    end else if (r_pulse_cnt != PW'(0)) begin
      w_pulse_nxt = r_pulse_cnt - PW'(1);
    end else begin
      w_pulse_nxt = r_pulse_cnt;
    end
    w_in_reset_nxt = !w_res_n_nxt || (w_pulse_nxt != PW'(0));
  end

  // Step counter, STEP_DONE flag and run-state selection.
  always_comb begin
    w_step_nxt = r_step_cnt;
    w_done_set = 1'b0;
    // RESET beats RUN beats STEP: both RESET and RUN hold the count at zero.
    if (w_in_reset_nxt || w_run_nxt) begin
      w_step_nxt = STEP_WIDTH'(0);
    end else if (w_wr_step) begin
      w_step_nxt = spi_data_i[STEP_WIDTH-1:0];
    end else if ((r_state == S_STEP) && cpu_done_i && (r_step_cnt != STEP_WIDTH'(0))) begin
      w_step_nxt = r_step_cnt - STEP_WIDTH'(1);
      w_done_set = (r_step_cnt == STEP_WIDTH'(1));
    end else begin
      w_step_nxt = r_step_cnt;
    end

    // Setting STEP_DONE wins over a simultaneous write-one-to-clear.
    if (w_done_set) begin
      w_step_done_nxt = 1'b1;
    end else if (w_wr_status && spi_data_i[3]) begin
      w_step_done_nxt = 1'b0;
    end else begin
      w_step_done_nxt = r_step_done;
    end

    if (w_in_reset_nxt) begin
      w_state_nxt = S_RESET;
    end else if (w_run_nxt) begin
      w_state_nxt = S_RUN;
    end else if (w_step_nxt != STEP_WIDTH'(0)) begin
      w_state_nxt = S_STEP;
    end else begin
      w_state_nxt = S_HALT;
    end
  end

  // Read mux over the current register contents.
  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = 8'h00;
    if (w_hit_ctrl) begin
      w_rd_hit  = 1'b1;
      w_rd_data = {6'b000000, r_run, r_res_n};
    end else if (w_hit_step) begin
      w_rd_hit  = 1'b1;
      w_rd_data = 8'(r_step_cnt);
    end else if (w_hit_status) begin
      w_rd_hit  = 1'b1;
      // Bit0 reports the whole RESET condition (RES_N low or pulse active).
      w_rd_data = {4'b0000, r_step_done, (r_step_cnt != STEP_WIDTH'(0)),
                   r_cpu_ready, r_cpu_res};
    end else begin
      w_rd_hit  = 1'b0;
      w_rd_data = 8'h00;
    end
  end

  // State registers, registered CPU lines and the registered read port.
  always_ff @(posedge clk_bus_i) begin
    if (reset_i) begin
      r_res_n      <= 1'b0;
      r_run        <= 1'b0;
      r_pulse_cnt  <= PW'(0);
      r_step_cnt   <= STEP_WIDTH'(0);
      r_step_done  <= 1'b0;
      r_state      <= S_RESET;
      r_cpu_res    <= 1'b1;
      r_cpu_ready  <= 1'b0;
      r_rd_data    <= 8'h00;
      r_rd_hit     <= 1'b0;
    end else begin
      r_res_n      <= w_res_n_nxt;
      r_run        <= w_run_nxt;
      r_pulse_cnt  <= w_pulse_nxt;
      r_step_cnt   <= w_step_nxt;
      r_step_done  <= w_step_done_nxt;
      r_state      <= w_state_nxt;
      r_cpu_res    <= w_in_reset_nxt;
      case (w_state_nxt)
        S_RUN:   r_cpu_ready <= 1'b1;
        S_STEP:  r_cpu_ready <= 1'b1;
        S_HALT:  r_cpu_ready <= 1'b0;
        S_RESET: r_cpu_ready <= 1'b0;
        default: r_cpu_ready <= 1'b0;
      endcase
      r_rd_hit <= spi_rd_en_i && w_rd_hit;
      if (spi_rd_en_i && w_rd_hit) begin
        r_rd_data <= w_rd_data;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign spi_data_o   = r_rd_data;
  assign spi_rd_hit_o = r_rd_hit;
  assign cpu_res_o    = r_cpu_res;
  assign cpu_ready_o  = r_cpu_ready;

endmodule

// File: tb/tb_cpu_control.sv
// -----------------------------------------------------------------------------
// tb_cpu_control
//   Directed bench for cpu_control. A behavioural model tracks the register
//   contents with plain integers and derives RES/RDY from them; a compare
//   process checks every DUT output against it on each falling edge, and the
//   directed sequence adds literal expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_cpu_control;

  localparam int          AW    = 17;
  localparam logic [16:0] BASE  = 17'h0E80C;
  localparam int          PULSE = 16;

  logic        clk_bus_i;
  logic        reset_i;
  logic [16:0] spi_addr_i;
  logic [7:0]  spi_data_i;
  logic        spi_wr_en_i;
  logic        spi_rd_en_i;
  logic [7:0]  spi_data_o;
  logic        spi_rd_hit_o;
  logic        cpu_done_i;
  logic        cpu_res_o;
  logic        cpu_ready_o;

  int checks;
  int errors;
  bit chk_en;

  cpu_control #(
    .ADDR_WIDTH       (AW),
    .BASE_ADDR        (BASE),
    .RES_PULSE_CYCLES (PULSE),
    .STEP_WIDTH       (8)
  ) dut (
    .clk_bus_i    (clk_bus_i),
    .reset_i      (reset_i),
    .spi_addr_i   (spi_addr_i),
    .spi_data_i   (spi_data_i),
    .spi_wr_en_i  (spi_wr_en_i),
    .spi_rd_en_i  (spi_rd_en_i),
    .spi_data_o   (spi_data_o),
    .spi_rd_hit_o (spi_rd_hit_o),
    .cpu_done_i   (cpu_done_i),
    .cpu_res_o    (cpu_res_o),
    .cpu_ready_o  (cpu_ready_o)
  );

  initial clk_bus_i = 1'b0;
  always #5 clk_bus_i = ~clk_bus_i;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    bit         res_n;
    bit         run;
    int         pulse_left;
    int         steps;
    bit         done_flag;
    bit         res;
    bit         ready;
    logic [7:0] rd_data;
    bit         rd_hit;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.res_n = 1'b0; r.run = 1'b0; r.pulse_left = 0; r.steps = 0;
    r.done_flag = 1'b0; r.res = 1'b1; r.ready = 1'b0;
    r.rd_data = 8'h00; r.rd_hit = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, bit rst, logic [16:0] a,
                                        logic [7:0] d, bit wr, bit rd, bit done);
    model_t n;
    bit in_reset;
    bit set_done;
    if (rst) return model_reset();
    n = c;
    set_done = 1'b0;
    // reads see the register file as it stands before this edge
    n.rd_hit = 1'b0;
    if (rd && a == BASE) begin
      n.rd_hit = 1'b1; n.rd_data = {6'd0, c.run, c.res_n};
    end else if (rd && a == BASE + 17'd1) begin
      n.rd_hit = 1'b1; n.rd_data = 8'(c.steps);
    end else if (rd && a == BASE + 17'd2) begin
      n.rd_hit = 1'b1;
      n.rd_data = {4'd0, c.done_flag, c.steps > 0, c.ready, c.res};
    end
    if (wr && a == BASE) begin
      n.res_n = d[0]; n.run = d[1];
    end
    if (wr && a == BASE && d[2]) n.pulse_left = PULSE;
    else if (c.pulse_left > 0) n.pulse_left = c.pulse_left - 1;
    in_reset = !n.res_n || (n.pulse_left > 0);
    if (in_reset || n.run) n.steps = 0;
    else if (wr && a == BASE + 17'd1) n.steps = int'(d);
    else if (done && c.ready && c.steps > 0) begin
      n.steps = c.steps - 1;
      set_done = (n.steps == 0);
    end
    if (wr && a == BASE + 17'd2 && d[3]) n.done_flag = 1'b0;
    if (set_done) n.done_flag = 1'b1;
    n.res   = in_reset;
    n.ready = !in_reset && (n.run || n.steps > 0);
    return n;
  endfunction

  // Advance the model on every rising edge from the same inputs the DUT sees.
  always @(posedge clk_bus_i) begin
    m <= model_next(m, reset_i, spi_addr_i, spi_data_i, spi_wr_en_i,
                    spi_rd_en_i, cpu_done_i);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk_bus_i) begin
    if (chk_en) begin
      chk("model_res",     32'(cpu_res_o),    32'(m.res));
      chk("model_ready",   32'(cpu_ready_o),  32'(m.ready));
      chk("model_rd_hit",  32'(spi_rd_hit_o), 32'(m.rd_hit));
      chk("model_rd_data", 32'(spi_data_o),   32'(m.rd_data));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_bus_i);
  endtask

  task automatic wr(input logic [16:0] a, input logic [7:0] d, input bit done);
    spi_addr_i = a; spi_data_i = d; spi_wr_en_i = 1'b1; cpu_done_i = done;
    @(negedge clk_bus_i);
    spi_wr_en_i = 1'b0; cpu_done_i = 1'b0;
  endtask

  task automatic pulse_done();
    cpu_done_i = 1'b1;
    @(negedge clk_bus_i);
    cpu_done_i = 1'b0;
  endtask

  task automatic rd(input string name, input logic [16:0] a, input logic [7:0] exp);
    spi_addr_i = a; spi_rd_en_i = 1'b1;
    @(negedge clk_bus_i);
    spi_rd_en_i = 1'b0;
    chk({name, "_hit"}, 32'(spi_rd_hit_o), 32'd1);
    chk(name, 32'(spi_data_o), 32'(exp));
  endtask

  int res_hi;

  initial begin
    checks = 0; errors = 0; chk_en = 1'b0;
    reset_i = 1'b1; spi_addr_i = 17'd0; spi_data_i = 8'h00;
    spi_wr_en_i = 1'b0; spi_rd_en_i = 1'b0; cpu_done_i = 1'b0;
    @(negedge clk_bus_i);
    chk_en = 1'b1;
    @(negedge clk_bus_i);
    reset_i = 1'b0;

    // reset state
    chk("rst_res", 32'(cpu_res_o), 32'd1);
    chk("rst_ready", 32'(cpu_ready_o), 32'd0);
    chk("rst_hit", 32'(spi_rd_hit_o), 32'd0);
    rd("rst_ctrl", BASE, 8'h00);
    rd("rst_step", BASE + 17'd1, 8'h00);
    rd("rst_status", BASE + 17'd2, 8'h01);

    // run, unmapped and aliased addresses
    wr(BASE, 8'h03, 1'b0);
    chk("run_res", 32'(cpu_res_o), 32'd0);
    chk("run_ready", 32'(cpu_ready_o), 32'd1);
    rd("run_status", BASE + 17'd2, 8'h02);
    wr(BASE + 17'd3, 8'hFF, 1'b0);
    wr(BASE ^ 17'h10000, 8'h00, 1'b0);
    rd("alias_ctrl", BASE, 8'h03);
    spi_addr_i = BASE + 17'd3; spi_rd_en_i = 1'b1;
    @(negedge clk_bus_i);
    spi_rd_en_i = 1'b0;
    chk("unmapped_hit", 32'(spi_rd_hit_o), 32'd0);

    // reset pulse restarted after 10 cycles: 10 + PULSE cycles high
    wr(BASE, 8'h05, 1'b0);
    res_hi = 0;
    for (int i = 0; i < 60; i++) begin
      if (cpu_res_o) res_hi++;
      if (i == 9) wr(BASE, 8'h05, 1'b0);
      else @(negedge clk_bus_i);
    end
    chk("pulse_len", 32'(res_hi), 32'd26);
    rd("pulse_status", BASE + 17'd2, 8'h00);

    // three counted steps
    wr(BASE, 8'h01, 1'b0);
    wr(BASE + 17'd1, 8'd3, 1'b0);
    chk("step_ready", 32'(cpu_ready_o), 32'd1);
    pulse_done();
    rd("step_rd2", BASE + 17'd1, 8'd2);
    pulse_done();
    rd("step_rd1", BASE + 17'd1, 8'd1);
    chk("step_ready_mid", 32'(cpu_ready_o), 32'd1);
    pulse_done();
    chk("step_ready_end", 32'(cpu_ready_o), 32'd0);
    rd("step_rd0", BASE + 17'd1, 8'd0);
    rd("step_status", BASE + 17'd2, 8'h08);
    wr(BASE + 17'd2, 8'h08, 1'b0);
    rd("w1c_status", BASE + 17'd2, 8'h00);

    // saturation: done while halted with zero count
    pulse_done();
    rd("sat_step", BASE + 17'd1, 8'd0);

    // step write beats simultaneous done; RUN clears the count
    wr(BASE + 17'd1, 8'd5, 1'b0);
    wr(BASE + 17'd1, 8'd2, 1'b1);
    rd("wr_vs_done", BASE + 17'd1, 8'd2);
    wr(BASE, 8'h03, 1'b0);
    rd("run_clears", BASE + 17'd1, 8'd0);
    chk("run_keeps_ready", 32'(cpu_ready_o), 32'd1);

    // set beats simultaneous W1C
    wr(BASE, 8'h01, 1'b0);
    wr(BASE + 17'd1, 8'd1, 1'b0);
    wr(BASE + 17'd2, 8'h08, 1'b1);
    rd("set_vs_w1c", BASE + 17'd2, 8'h08);
    wr(BASE + 17'd2, 8'h08, 1'b0);

    // pulse mid-step: count dropped, no STEP_DONE
    wr(BASE + 17'd1, 8'd4, 1'b0);
    rd("mid_step4", BASE + 17'd1, 8'd4);
    wr(BASE, 8'h05, 1'b0);
    chk("mid_pulse_ready", 32'(cpu_ready_o), 32'd0);
    chk("mid_pulse_res", 32'(cpu_res_o), 32'd1);
    pulse_done();
    rd("mid_pulse_step", BASE + 17'd1, 8'd0);
    rd("mid_pulse_status", BASE + 17'd2, 8'h01);

    // reset_i in the middle of the pulse
    reset_i = 1'b1;
    @(negedge clk_bus_i);
    reset_i = 1'b0;
    chk("rerst_res", 32'(cpu_res_o), 32'd1);
    chk("rerst_ready", 32'(cpu_ready_o), 32'd0);
    chk("rerst_data", 32'(spi_data_o), 32'd0);
    rd("rerst_ctrl", BASE, 8'h00);
    rd("rerst_step", BASE + 17'd1, 8'h00);
    rd("rerst_status", BASE + 17'd2, 8'h01);
    idle(20);
    chk("rerst_still_res", 32'(cpu_res_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
